// File: rtl/bit_stream_gen.sv
// Programmable-rate NRZ serial transmitter: word-mode (one-word holding buffer
// feeding a shift register, MSB first) or PRBS7 mode, with reference bit clock.
module bit_stream_gen #(
    parameter int         CLK_LEN   = 16,
    parameter int         WORD_LEN  = 8,
    parameter logic [6:0] PRBS_SEED = 7'h7F
) (
    input  logic                clk_300M,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                mode,
    input  logic [CLK_LEN-1:0]  bit_period,
    input  logic [WORD_LEN-1:0] data_in,
    input  logic                data_valid,
    output logic                data_ready,
    output logic                signal_out,
    output logic                bit_strobe,
    output logic                clk_ref,
    output logic                underrun
);
    localparam logic [6:0] SEED = (PRBS_SEED == 7'd0) ? 7'h7F : PRBS_SEED;
    localparam int BW = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state;
    logic [CLK_LEN-1:0]  pc, per, per_nxt, pc_inc;
    logic [WORD_LEN-1:0] hold, sh, sh_nxt;
    logic                hold_full, mode_r;
    logic [BW-1:0]       bidx;
    logic [6:0]          lfsr, lfsr_nxt;
    logic                take, consume, go, bit_end, last_bit;

    assign data_ready = !hold_full;
    assign per_nxt    = (bit_period < CLK_LEN'(2)) ? CLK_LEN'(2) : bit_period;

    always_comb begin
        pc_inc   = pc + 1'b1;
        sh_nxt   = sh << 1;
        lfsr_nxt = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        bit_end  = (state == SHIFT) && (pc == per - 1'b1);
        last_bit = (bidx == BW'(WORD_LEN - 1));
        go       = (state == IDLE) && enable && (mode || hold_full);
        take     = data_valid && !hold_full;
        // Buffer empties on word-mode start from IDLE or on a back-to-back reload.
        consume  = (go && !mode) ||
                   (bit_end && enable && !mode_r && last_bit && hold_full);
    end

    always_ff @(posedge clk_300M or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= '0;
            per        <= CLK_LEN'(2);
            hold       <= '0;
            sh         <= '0;
            hold_full  <= 1'b0;
            mode_r     <= 1'b0;
            bidx       <= '0;
            lfsr       <= SEED;
            signal_out <= 1'b0;
            bit_strobe <= 1'b0;
            clk_ref    <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            bit_strobe <= 1'b0;
            underrun   <= 1'b0;
            if (take) hold <= data_in;
            hold_full <= take || (hold_full && !consume);
            case (state)
                IDLE: begin
                    signal_out <= 1'b0;
                    clk_ref    <= 1'b0;
                    pc         <= '0;
                    if (go) begin
                        state      <= SHIFT;
                        mode_r     <= mode;
                        per        <= per_nxt;
                        bit_strobe <= 1'b1;
                        bidx       <= '0;
                        if (mode) begin
                            signal_out <= lfsr[6];
                        end else begin
                            sh         <= hold;
                            signal_out <= hold[WORD_LEN-1];
                        end
                    end
                end
                SHIFT: begin
                    if (!bit_end) begin
                        pc      <= pc_inc;
                        clk_ref <= (pc_inc >= (per >> 1));
                    end else begin
                        pc      <= '0;
                        clk_ref <= 1'b0;
                        // LFSR advances past the finished bit even when stopping,
                        // so a later re-enable resumes the sequence.
                        if (mode_r) lfsr <= lfsr_nxt;
                        if (!enable) begin
                            state      <= IDLE;
                            signal_out <= 1'b0;
                        end else if (mode_r) begin
                            signal_out <= lfsr_nxt[6];
                            bit_strobe <= 1'b1;
                            per        <= per_nxt;
                        end else if (!last_bit) begin
                            sh         <= sh_nxt;
                            signal_out <= sh_nxt[WORD_LEN-1];
                            bidx       <= bidx + 1'b1;
                            bit_strobe <= 1'b1;
                            per        <= per_nxt;
                        end else if (hold_full) begin
                            sh         <= hold;
                            signal_out <= hold[WORD_LEN-1];
                            bidx       <= '0;
                            bit_strobe <= 1'b1;
                            per        <= per_nxt;
                        end else begin
                            state      <= IDLE;
                            signal_out <= 1'b0;
                            underrun   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_stream_gen.sv
// Randomized bench for bit_stream_gen: the driver queues expected word bits,
// a negedge monitor steps a spec-level model and checks every output cycle.
module tb_bit_stream_gen;
    logic        clk_300M = 0, rst_n = 1, enable = 0, mode = 0, data_valid = 0;
    logic [15:0] bit_period = 16'd4;
    logic [7:0]  data_in = 8'h00;
    logic        data_ready, signal_out, bit_strobe, clk_ref, underrun;

    int checks = 0, failures = 0;
    int und_cnt = 0, strobe_cnt = 0;
    bit exp_q[$];
    bit obs[$];
    bit prbs_seq[127];
    logic [7:0] words[$];

    bit_stream_gen dut (
        .clk_300M(clk_300M), .rst_n(rst_n), .enable(enable), .mode(mode),
        .bit_period(bit_period), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .signal_out(signal_out), .bit_strobe(bit_strobe),
        .clk_ref(clk_ref), .underrun(underrun)
    );

    always #5 clk_300M = ~clk_300M;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] packq(input int start, input int n);
        logic [31:0] v = 0;
        for (int i = start; i < start + n; i++)
            v = {v[30:0], (i < obs.size()) ? obs[i] : 1'b0};
        return v;
    endfunction

    // Monitor: spec-level model of run/idle, bit timing, buffer occupancy.
    bit   m_run, m_prbs, m_full, cur_bit, p_rst;
    int   pc, per, widx, pidx;
    logic p_en, p_mode, p_dv;
    logic [15:0] p_bp;

    always @(negedge clk_300M) begin
        bit xfer, cons, e_str, e_und;
        if (bit_strobe === 1'b1) begin obs.push_back(signal_out); strobe_cnt++; end
        if (underrun === 1'b1) und_cnt++;
        if (!rst_n || !p_rst) begin
            m_run = 0; m_prbs = 0; m_full = 0; pc = 0; per = 2; widx = 0; pidx = 0; cur_bit = 0;
            if (!rst_n) exp_q.delete();
            chk("rst_signal_out", signal_out, 0);
            chk("rst_bit_strobe", bit_strobe, 0);
            chk("rst_clk_ref", clk_ref, 0);
            chk("rst_underrun", underrun, 0);
            chk("rst_data_ready", data_ready, 1);
        end else begin
            xfer = p_dv && !m_full;
            cons = 0; e_str = 0; e_und = 0;
            if (!m_run) begin
                if (p_en && (p_mode || m_full)) begin
                    m_run = 1; m_prbs = p_mode; cons = !p_mode; widx = 0; e_str = 1;
                    pc = 0; per = (p_bp < 2) ? 2 : int'(p_bp);
                end
            end else if (pc == per - 1) begin
                pc = 0;
                if (!p_en) begin
                    m_run = 0;
                    if (!m_prbs) repeat (8 - widx) if (exp_q.size() > 0) void'(exp_q.pop_front());
                end else if (!m_prbs && widx == 8) begin
                    if (m_full) begin
                        cons = 1; widx = 0; e_str = 1; per = (p_bp < 2) ? 2 : int'(p_bp);
                    end else begin
                        m_run = 0; e_und = 1;
                    end
                end else begin
                    e_str = 1; per = (p_bp < 2) ? 2 : int'(p_bp);
                end
            end else begin
                pc++;
            end
            m_full = xfer || (m_full && !cons);
            if (e_str) begin
                if (m_prbs) begin
                    cur_bit = prbs_seq[pidx]; pidx = (pidx + 1) % 127;
                end else begin
                    chk("exp_q_has_bit", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) cur_bit = exp_q.pop_front();
                    widx++;
                end
            end
            chk("bit_strobe", bit_strobe, e_str);
            chk("underrun", underrun, e_und);
            chk("signal_out", signal_out, m_run ? cur_bit : 1'b0);
            chk("clk_ref", clk_ref, m_run && (pc >= per / 2));
            chk("data_ready", data_ready, !m_full);
        end
        p_rst = rst_n; p_en = enable; p_mode = mode; p_dv = data_valid; p_bp = bit_period;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_300M);
        #1;
    endtask

    task automatic write_word(input logic [7:0] w);
        int t = 0;
        data_valid = 1; data_in = w;
        @(negedge clk_300M);
        while (!data_ready && t < 2000) begin @(negedge clk_300M); t++; end
        chk("write_timeout", t < 2000, 1);
        for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
        @(posedge clk_300M); #1;
        data_valid = 0;
    endtask

    task automatic wait_und(input int target, input int maxc);
        int t = 0;
        while (und_cnt < target && t < maxc) begin cyc(1); t++; end
        chk("underrun_count", und_cnt, target);
    endtask

    initial begin
        logic [6:0] l = 7'h7F;
        int s;
        logic [7:0] w;
        for (int i = 0; i < 127; i++) begin
            prbs_seq[i] = l[6];
            l = {l[5:0], l[6] ^ l[5]};
        end

        #1 rst_n = 0;
        #1;
        chk("init_signal_out", signal_out, 0);
        chk("init_data_ready", data_ready, 1);
        chk("init_clk_ref", clk_ref, 0);
        cyc(3);
        rst_n = 1;
        cyc(2);

        // Single word at P=4
        bit_period = 4; obs.delete();
        write_word(8'hA5);
        enable = 1;
        wait_und(1, 100);
        chk("a5_bits", packq(0, 8), 32'hA5);
        chk("a5_nbits", obs.size(), 8);
        cyc(3);
        chk("a5_idle_out", signal_out, 0);

        // Back-to-back words at P=6
        bit_period = 6; obs.delete();
        write_word(8'hF0);
        write_word(8'h0F);
        wait_und(2, 300);
        chk("b2b_bits", packq(0, 16), 32'hF00F);
        chk("b2b_nbits", obs.size(), 16);
        cyc(20);
        chk("b2b_one_underrun", und_cnt, 2);

        // PRBS at P=3, then pause/resume
        mode = 1; bit_period = 3; obs.delete();
        cyc(3 * 132 + 4);
        chk("prbs_first8", packq(0, 8), 32'hFE);
        chk("prbs_len", obs.size() >= 130, 1);
        for (int i = 0; i < 3; i++) chk("prbs_period127", obs[i + 127], obs[i]);
        enable = 0;
        cyc(10);
        enable = 1;
        cyc(40);
        enable = 0;
        cyc(8);
        mode = 0;

        // Minimum period, then a mid-bit period change
        w = 8'($urandom);
        write_word(w);
        bit_period = 1;
        enable = 1;
        write_word(8'($urandom));
        cyc(5);
        bit_period = 5;
        wait_und(3, 400);

        // Handshake: 10 words with data_valid held, random period changes
        bit_period = 3; obs.delete(); words.delete();
        for (int k = 0; k < 10; k++) begin
            w = 8'($urandom);
            words.push_back(w);
            write_word(w);
            if ($urandom_range(0, 2) == 0) bit_period = 16'($urandom_range(0, 5));
        end
        wait_und(4, 1500);
        chk("hs_nbits", obs.size(), 80);
        for (int k = 0; k < 10; k++) chk("hs_word", packq(8 * k, 8), {24'h0, words[k]});

        // Enable drop mid-word: remainder discarded, buffer retained
        bit_period = 4; enable = 0;
        cyc(2);
        write_word(8'h3C);
        enable = 1;
        write_word(8'h99);
        cyc(9);
        enable = 0;
        cyc(12);
        chk("buffer_retained", data_ready, 0);
        obs.delete();
        enable = 1;
        wait_und(5, 300);
        chk("resume_word", packq(0, 8), 32'h99);

        // Asynchronous reset mid-bit
        mode = 1; bit_period = 5;
        cyc(12);
        #2 rst_n = 0;
        #1;
        chk("arst_signal_out", signal_out, 0);
        chk("arst_bit_strobe", bit_strobe, 0);
        chk("arst_clk_ref", clk_ref, 0);
        chk("arst_underrun", underrun, 0);
        chk("arst_data_ready", data_ready, 1);
        s = strobe_cnt;
        cyc(5);
        chk("no_strobe_in_reset", strobe_cnt, s);
        enable = 0; mode = 0;
        rst_n = 1;
        cyc(3);
        obs.delete();
        mode = 1; enable = 1;
        cyc(30);
        chk("prbs_reseed", packq(0, 4), 32'hF);
        enable = 0;
        cyc(8);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bit_stream_gen.md
Name: bit_stream_gen

Overview:
- Programmable-rate NRZ serial transmitter. It is the source end of the link that the bit clock recovery block consumes.
- Drives `signal_out` at a bit period set in base-clock cycles. Data comes either from parallel words over a valid/ready handshake or from an internal PRBS7 generator.
- Emits a reference bit clock (`clk_ref`), so the bench or board can compare it against the recovered clock.

Parameters:
- CLK_LEN, 16: width of `bit_period` and of the internal period counter.
- WORD_LEN, 8: width of the parallel data word. Words are serialised MSB first.
- PRBS_SEED, 7'h7F: LFSR load value. A value of 0 is replaced by 7'h7F.

Ports:
- clk_300M  in  1  base clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request.
- mode  in  1  0 = word mode, 1 = PRBS7 mode.
- bit_period  in  CLK_LEN  bit duration in clk_300M cycles.
- data_in  in  WORD_LEN  parallel word.
- data_valid  in  1  `data_in` is valid.
- data_ready  out  1  holding buffer can accept a word.
- signal_out  out  1  serial NRZ output (registered).
- bit_strobe  out  1  one-cycle pulse in the first cycle of every transmitted bit.
- clk_ref  out  1  reference bit clock; rises mid-bit.
- underrun  out  1  one-cycle pulse when a word boundary finds no data.

Behaviour:
- Reset (async, rst_n=0) values:
  - outputs: signal_out=0, bit_strobe=0, clk_ref=0, underrun=0, data_ready=1.
  - internal: state=IDLE, holding buffer empty, LFSR=PRBS_SEED, counters=0.
  - Reset asserted mid-transfer aborts immediately and discards buffered data.
- Effective period P = max(`bit_period`, 2).
  - P is latched at the first cycle of each bit.
  - A `bit_period` change therefore takes effect on the next bit, never mid-bit.
- Period counter `pc` counts 0..P-1 within each bit.
  - At pc=P-1 the bit ends, pc wraps to 0 and the next bit starts.
  - `clk_ref` = 0 for pc < P/2 (floor), 1 otherwise.
- Holding buffer (one word) and handshake:
  - data_ready = !hold_full.
  - Transfer occurs on a cycle with data_valid & data_ready; hold_full sets the next cycle.
  - A transfer and a buffer-to-shift-register move in the same cycle are both honoured: the buffer stays full with the new word.
  - data_ready is not gated by mode or enable.
- State IDLE:
  - signal_out=0, pc held at 0, clk_ref=0.
  - Go to SHIFT when enable=1 and either mode=1, or mode=0 with hold_full=1.
  - `mode` is sampled only on IDLE exit.
  - On exit the first bit is loaded. It appears on signal_out with bit_strobe=1 on the cycle after the transition decision (1-cycle latency).
- State SHIFT, word mode:
  - The shift register supplies the MSB first. Bit index counts 0..WORD_LEN-1.
  - After bit WORD_LEN-1, if hold_full: the buffer moves into the shift register and transmission continues with no gap (back-to-back words).
  - Otherwise: underrun pulses for 1 cycle on the cycle the last bit ends, and the state returns to IDLE.
- State SHIFT, PRBS mode:
  - Output bit = lfsr[6]; at each bit end, lfsr <= {lfsr[5:0], lfsr[6]^lfsr[5]}. Period 127.
  - The holding buffer is ignored (it is still fillable).
  - Underrun never fires.
- Enable deassert in SHIFT:
  - Sampled at bit end only. The current bit completes, then the state goes to IDLE.
  - Word mode: a partially sent word is discarded and the holding buffer is retained.
  - PRBS mode: the LFSR keeps its state, so the sequence resumes on re-enable.
- Simultaneous events at a bit end: enable=0 has priority over both underrun and the word reload.

Test Plan:
- Word, single: P=4, write 0xA5, enable=1.
  - Required: signal_out = 1,0,1,0,0,1,0,1, each bit held 4 cycles.
  - bit_strobe every 4th cycle; clk_ref rises at pc=2 of each bit.
  - After the 32nd bit cycle: underrun pulse, then IDLE with signal_out=0.
- Back-to-back words: P=6, write 0xF0 then 0x0F while the first word is shifting.
  - Required: 16 bits 1111000000001111 with no idle gap; exactly one underrun, after bit 16.
- PRBS: mode=1, P=3.
  - Required: first 8 bits 1,1,1,1,1,1,1,0.
  - Sequence repeats after 127 bits, i.e. 381 cycles.
- Period change and minimum period:
  - Set bit_period=1: each bit lasts 2 cycles.
  - Change to 5 mid-bit: the current bit completes at the old length and the next bit lasts 5 cycles.
- Handshake: hold data_valid=1 with consecutive words.
  - Required: data_ready drops for exactly the cycles the buffer is full.
  - No word is lost or duplicated; check against a scoreboard over 10 words.
- Reset and enable:
  - Assert rst_n=0 mid-bit: all outputs go to reset values asynchronously, with no further strobes.
  - Deassert enable mid-bit: the current bit finishes, then the block enters IDLE.
